// File: rtl/vga_monitor.sv
// VGA timing monitor: locks onto an incoming sync stream, validates line/frame
// timing, reports active-window pixels and a per-frame additive checksum.
module vga_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_SYNC_LEN  = 97,
    parameter int V_SYNC_LEN  = 3,
    parameter int H_ACT_START = 97,
    parameter int H_ACT_LEN   = 640,
    parameter int V_ACT_START = 3,
    parameter int V_ACT_LEN   = 480
) (
    input  logic        CLOCK_25,
    input  logic        reset,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [23:0] pix_rgb,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [15:0] frame_count,
    output logic [3:0]  err_flags,
    output logic [7:0]  err_count
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
    localparam logic [11:0] H_WDOG_W  = 12'(2 * H_TOTAL);
    localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC_LEN);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
    localparam logic [9:0]  V_SYNC_W  = 10'(V_SYNC_LEN);
    localparam logic [11:0] H_ACT_LO  = 12'(H_ACT_START);
    localparam logic [11:0] H_ACT_HI  = 12'(H_ACT_START + H_ACT_LEN);
    localparam logic [10:0] V_ACT_LO  = 11'(V_ACT_START);
    localparam logic [10:0] V_ACT_HI  = 11'(V_ACT_START + V_ACT_LEN);

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic        hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
    logic [23:0] rgb_s1_q, rgb_s1_d;
    logic        hs_prev_q, hs_prev_d, vs_ls_q, vs_ls_d;
    logic [10:0] h_cnt_q, h_cnt_d, hs_hi_q, hs_hi_d;
    logic [9:0]  v_cnt_q, v_cnt_d, vs_hi_q, vs_hi_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [23:0] pix_rgb_q, pix_rgb_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_sum_q, frame_sum_d, frame_count_q, frame_count_d;
    logic [3:0]  err_flags_q, err_flags_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        line_start, frame_start, chk_en, any_err, h_in, v_in;
    logic [3:0]  err_vec;
    logic [15:0] px_sum;

    always_comb begin
        hs_s1_d   = vga_hs;
        vs_s1_d   = vga_vs;
        rgb_s1_d  = {vga_r, vga_g, vga_b};
        hs_prev_d = hs_s1_q;

        line_start  = hs_s1_q && !hs_prev_q;
        frame_start = line_start && vs_s1_q && !vs_ls_q;

        h_cnt_d = line_start ? 11'd0 : sat_inc11(h_cnt_q);
        hs_hi_d = line_start ? 11'd1 : (hs_s1_q ? sat_inc11(hs_hi_q) : hs_hi_q);
        vs_ls_d = line_start ? vs_s1_q : vs_ls_q;
        v_cnt_d = frame_start ? 10'd0 : (line_start ? sat_inc10(v_cnt_q) : v_cnt_q);
        vs_hi_d = frame_start ? 10'd1
                : ((line_start && vs_s1_q) ? sat_inc10(vs_hi_q) : vs_hi_q);

        // Measurements close at the start that ends them; watchdog fires once on the exact count.
        chk_en     = (state_q != ST_SEARCH);
        err_vec    = 4'b0000;
        err_vec[0] = (line_start && chk_en && (({1'b0, h_cnt_q} + 12'd1) != H_TOTAL_W))
                   || (!line_start && ({1'b0, h_cnt_d} == H_WDOG_W));
        err_vec[1] = line_start && chk_en && (hs_hi_q != H_SYNC_W);
        err_vec[2] = frame_start && chk_en && (({1'b0, v_cnt_q} + 11'd1) != V_TOTAL_W);
        err_vec[3] = frame_start && chk_en && (vs_hi_q != V_SYNC_W);
        any_err    = |err_vec;

        state_d = state_q;
        case (state_q)
            ST_SEARCH: if (frame_start && !any_err) state_d = ST_CHECK;
            ST_CHECK: begin
                if (any_err)          state_d = ST_SEARCH;
                else if (frame_start) state_d = ST_LOCKED;
            end
            ST_LOCKED: if (any_err) state_d = ST_SEARCH;
            default:   state_d = ST_SEARCH;
        endcase

        h_in = ({1'b0, h_cnt_d} >= H_ACT_LO) && ({1'b0, h_cnt_d} < H_ACT_HI);
        v_in = ({1'b0, v_cnt_d} >= V_ACT_LO) && ({1'b0, v_cnt_d} < V_ACT_HI);
        pix_valid_d = (state_d == ST_LOCKED) && h_in && v_in;
        pix_x_d     = pix_valid_d ? 10'({1'b0, h_cnt_d} - H_ACT_LO) : 10'd0;
        pix_y_d     = pix_valid_d ? 10'({1'b0, v_cnt_d} - V_ACT_LO) : 10'd0;
        pix_rgb_d   = pix_valid_d ? rgb_s1_q : 24'd0;

        px_sum = 16'(rgb_s1_q[23:16]) + 16'(rgb_s1_q[15:8]) + 16'(rgb_s1_q[7:0]);
        acc_d  = frame_start ? 16'd0 : (pix_valid_d ? acc_q + px_sum : acc_q);

        // A frame is only reported when it ran start-to-start in LOCKED without fault.
        frame_done_d  = frame_start && (state_q == ST_LOCKED) && !any_err;
        frame_sum_d   = frame_done_d ? acc_q : frame_sum_q;
        frame_count_d = frame_done_d ? frame_count_q + 16'd1 : frame_count_q;

        err_flags_d = err_flags_q | err_vec;
        err_count_d = any_err ? sat_inc8(err_count_q) : err_count_q;
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            hs_s1_q       <= 1'b0;
            vs_s1_q       <= 1'b0;
            rgb_s1_q      <= 24'd0;
            hs_prev_q     <= 1'b0;
            vs_ls_q       <= 1'b0;
            h_cnt_q       <= 11'd0;
            hs_hi_q       <= 11'd0;
            v_cnt_q       <= 10'd0;
            vs_hi_q       <= 10'd0;
            state_q       <= ST_SEARCH;
            acc_q         <= 16'd0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            pix_rgb_q     <= 24'd0;
            frame_done_q  <= 1'b0;
            frame_sum_q   <= 16'd0;
            frame_count_q <= 16'd0;
            err_flags_q   <= 4'd0;
            err_count_q   <= 8'd0;
        end else begin
            hs_s1_q       <= hs_s1_d;
            vs_s1_q       <= vs_s1_d;
            rgb_s1_q      <= rgb_s1_d;
            hs_prev_q     <= hs_prev_d;
            vs_ls_q       <= vs_ls_d;
            h_cnt_q       <= h_cnt_d;
            hs_hi_q       <= hs_hi_d;
            v_cnt_q       <= v_cnt_d;
            vs_hi_q       <= vs_hi_d;
            state_q       <= state_d;
            acc_q         <= acc_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            frame_done_q  <= frame_done_d;
            frame_sum_q   <= frame_sum_d;
            frame_count_q <= frame_count_d;
            err_flags_q   <= err_flags_d;
            err_count_q   <= err_count_d;
        end
    end

    assign locked      = (state_q == ST_LOCKED);
    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_done  = frame_done_q;
    assign frame_sum   = frame_sum_q;
    assign frame_count = frame_count_q;
    assign err_flags   = err_flags_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_monitor.sv
// Scoreboard bench for vga_monitor on a scaled-down video timing (40x20 clocks/lines).
module tb_vga_monitor;

    localparam int HT  = 40;
    localparam int VT  = 20;
    localparam int HSL = 5;
    localparam int VSL = 3;
    localparam int HA  = 5;
    localparam int HL  = 32;
    localparam int VA  = 3;
    localparam int VL  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vga_hs = 1'b0, vga_vs = 1'b0;
    logic [7:0]  vga_r = 8'd0, vga_g = 8'd0, vga_b = 8'd0;
    logic        locked, pix_valid, frame_done;
    logic [9:0]  pix_x, pix_y;
    logic [23:0] pix_rgb;
    logic [15:0] frame_sum, frame_count;
    logic [3:0]  err_flags;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    vga_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC_LEN(HSL), .V_SYNC_LEN(VSL),
        .H_ACT_START(HA), .H_ACT_LEN(HL), .V_ACT_START(VA), .V_ACT_LEN(VL)
    ) dut (
        .CLOCK_25(clk), .reset(reset), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .frame_done(frame_done), .frame_sum(frame_sum),
        .frame_count(frame_count), .err_flags(err_flags), .err_count(err_count)
    );

    typedef struct {
        int          due;
        logic        lk;
        logic        pv;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
        logic        fd;
        logic [15:0] fsum;
        logic [15:0] fcnt;
        logic [3:0]  ef;
        logic [7:0]  ec;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step = 0;

    logic        lk_now = 1'b0;
    logic [15:0] acc_m = 16'd0, sum_m = 16'd0, cnt_m = 16'd0;
    logic [3:0]  ef_m = 4'd0;
    logic [7:0]  ec_m = 8'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", tag, step, got, exp);
        end
    endtask

    function automatic logic [7:0] inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic check_due();
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= step) begin
            e = sb.pop_front();
            check("locked",      32'(locked),      32'(e.lk));
            check("pix_valid",   32'(pix_valid),   32'(e.pv));
            check("pix_x",       32'(pix_x),       32'(e.x));
            check("pix_y",       32'(pix_y),       32'(e.y));
            check("pix_rgb",     32'(pix_rgb),     32'(e.rgb));
            check("frame_done",  32'(frame_done),  32'(e.fd));
            check("frame_sum",   32'(frame_sum),   32'(e.fsum));
            check("frame_count", 32'(frame_count), 32'(e.fcnt));
            check("err_flags",   32'(err_flags),   32'(e.ef));
            check("err_count",   32'(err_count),   32'(e.ec));
        end
    endtask

    // One sample per negedge; outputs for it are due two negedges later.
    task automatic drive(input logic rst_v, input logic hs, input logic vs, input logic [23:0] rgb);
        @(negedge clk);
        step++;
        check_due();
        reset  = rst_v;
        vga_hs = hs;
        vga_vs = vs;
        {vga_r, vga_g, vga_b} = rgb;
    endtask

    task automatic push(input logic pv, input int x, input int y, input logic [23:0] rgb,
                        input logic fd);
        exp_t e;
        e.due  = step + 2;
        e.lk   = lk_now;
        e.pv   = pv;
        e.x    = 10'(x);
        e.y    = 10'(y);
        e.rgb  = rgb;
        e.fd   = fd;
        e.fsum = sum_m;
        e.fcnt = cnt_m;
        e.ef   = ef_m;
        e.ec   = ec_m;
        sb.push_back(e);
    endtask

    task automatic drive_frame(input int n_lines, input int vs_lines, input int short_line,
                               input int rst_line, input logic lk, input logic fd,
                               input logic [3:0] err_start, input logic rnd);
        for (int l = 0; l < n_lines; l++) begin
            int len;
            len = (l == short_line) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                logic [23:0] rgb;
                logic        rst_v;
                logic        pv;
                logic        fd_now;
                rgb    = rnd ? 24'($urandom) : 24'h010203;
                rst_v  = (l == rst_line) && (h == HT / 2);
                fd_now = fd && (l == 0) && (h == 0);
                drive(rst_v, h < HSL, l < vs_lines, rgb);
                if (l == 0 && h == 0) begin
                    if (fd) begin
                        sum_m = acc_m;
                        cnt_m = cnt_m + 16'd1;
                    end
                    acc_m  = 16'd0;
                    lk_now = lk;
                    if (err_start != 4'd0) begin
                        ef_m = ef_m | err_start;
                        ec_m = inc8(ec_m);
                    end
                end
                if (short_line >= 0 && l == short_line + 1 && h == 0) begin
                    ef_m   = ef_m | 4'b0001;
                    ec_m   = inc8(ec_m);
                    lk_now = 1'b0;
                end
                if (rst_v) begin
                    foreach (sb[i]) begin
                        if (sb[i].due == step + 1) begin
                            sb[i].lk = 1'b0;  sb[i].pv = 1'b0;   sb[i].x = 10'd0;
                            sb[i].y = 10'd0;  sb[i].rgb = 24'd0; sb[i].fd = 1'b0;
                            sb[i].fsum = 16'd0; sb[i].fcnt = 16'd0;
                            sb[i].ef = 4'd0;  sb[i].ec = 8'd0;
                        end
                    end
                    lk_now = 1'b0;
                    acc_m  = 16'd0;
                    sum_m  = 16'd0;
                    cnt_m  = 16'd0;
                    ef_m   = 4'd0;
                    ec_m   = 8'd0;
                end
                pv = lk_now && (h >= HA) && (h < HA + HL) && (l >= VA) && (l < VA + VL);
                if (pv) acc_m = acc_m + 16'(rgb[23:16]) + 16'(rgb[15:8]) + 16'(rgb[7:0]);
                push(pv, pv ? h - HA : 0, pv ? l - VA : 0, pv ? rgb : 24'h0, fd_now);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete, step %0d", step);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) drive(1'b1, 1'b0, 1'b0, 24'h0);
        check("rst_locked",      32'(locked),      32'd0);
        check("rst_pix_valid",   32'(pix_valid),   32'd0);
        check("rst_pix_x",       32'(pix_x),       32'd0);
        check("rst_pix_y",       32'(pix_y),       32'd0);
        check("rst_pix_rgb",     32'(pix_rgb),     32'd0);
        check("rst_frame_done",  32'(frame_done),  32'd0);
        check("rst_frame_sum",   32'(frame_sum),   32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_err_flags",   32'(err_flags),   32'd0);
        check("rst_err_count",   32'(err_count),   32'd0);

        // Acquire lock, then constant colour frame and random frames.
        drive_frame(VT, VSL, -1, -1, 1'b0, 1'b0, 4'b0000, 1'b0);
        drive_frame(VT, VSL, -1, -1, 1'b1, 1'b0, 4'b0000, 1'b0);
        drive_frame(VT, VSL, -1, -1, 1'b1, 1'b1, 4'b0000, 1'b0);
        drive_frame(VT, VSL, -1, -1, 1'b1, 1'b1, 4'b0000, 1'b1);
        // One short line, then relock.
        drive_frame(VT, VSL,  6, -1, 1'b1, 1'b1, 4'b0000, 1'b1);
        drive_frame(VT, VSL, -1, -1, 1'b0, 1'b0, 4'b0000, 1'b1);
        drive_frame(VT, VSL, -1, -1, 1'b1, 1'b0, 4'b0000, 1'b1);
        // Reset mid-line while locked, then relock.
        drive_frame(VT, VSL, -1, 10, 1'b1, 1'b1, 4'b0000, 1'b1);
        drive_frame(VT, VSL, -1, -1, 1'b0, 1'b0, 4'b0000, 1'b1);
        drive_frame(VT, VSL, -1, -1, 1'b1, 1'b0, 4'b0000, 1'b1);
        drive_frame(VT, VSL, -1, -1, 1'b1, 1'b1, 4'b0000, 1'b1);

        // HS held low: watchdog trips once after 2*HT clocks without a line start.
        for (int k = 0; k < 3 * HT; k++) begin
            drive(1'b0, 1'b0, 1'b0, 24'($urandom));
            if (k == HT) begin
                ef_m   = ef_m | 4'b0001;
                ec_m   = inc8(ec_m);
                lk_now = 1'b0;
            end
            push(1'b0, 0, 0, 24'h0, 1'b0);
        end
        drive_frame(VT, VSL, -1, -1, 1'b0, 1'b0, 4'b0000, 1'b1);
        drive_frame(VT, VSL, -1, -1, 1'b1, 1'b0, 4'b0000, 1'b1);
        drive_frame(VT, VSL, -1,  5, 1'b1, 1'b1, 4'b0000, 1'b1);

        // Short VS pulse, then a frame one line short.
        drive_frame(VT, VSL, -1, -1, 1'b0, 1'b0, 4'b0000, 1'b1);
        drive_frame(VT, VSL, -1, -1, 1'b1, 1'b0, 4'b0000, 1'b1);
        drive_frame(VT, 2,   -1, -1, 1'b1, 1'b1, 4'b0000, 1'b1);
        drive_frame(VT, VSL, -1, -1, 1'b0, 1'b0, 4'b1000, 1'b1);
        drive_frame(VT, VSL, -1, -1, 1'b0, 1'b0, 4'b0000, 1'b1);
        drive_frame(VT, VSL, -1, -1, 1'b1, 1'b0, 4'b0000, 1'b1);
        drive_frame(VT - 1, VSL, -1, -1, 1'b1, 1'b1, 4'b0000, 1'b1);
        drive_frame(VT, VSL, -1, -1, 1'b0, 1'b0, 4'b0100, 1'b1);

        repeat (2) drive(1'b0, 1'b0, 1'b0, 24'h0);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
